// File: rtl/fir_coeff_loader.sv
// Coefficient-reload sequencer for the symmetric folded FIR: streams host words into c_WE/c_in/c_addr.
// Optional checksum over the burst is enabled by defining FIR_COEFF_CHK_EN.
module fir_coeff_loader #(
  parameter int ORD   = 256,
  parameter int C     = 16,
  parameter int AW    = $clog2((ORD + 1) / 2),
  parameter int FLUSH = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          fs_tick,
  input  logic          s_valid,
  input  logic [C-1:0]  s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic [C-1:0]  exp_sum,
  output logic          c_WE,
  output logic [C-1:0]  c_in,
  output logic [AW-1:0] c_addr,
  output logic          busy,
  output logic          mute,
  output logic          done,
  output logic          err,
  output logic          chk_err
);

  localparam int NC = (ORD + 1) / 2;
  localparam int FW = $clog2(FLUSH + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [AW-1:0] cnt;
  logic [FW-1:0] fcnt;
  logic          beat;
  logic          at_top;
  logic          end_beat;
  logic          to_done;
  logic          take_start;

  // Handshake is a pure state decode so s_ready never depends on s_valid.
  assign s_ready    = (state == S_LOAD);
  assign beat       = s_valid & s_ready;
  assign at_top     = (cnt == AW'(NC - 1));
  assign end_beat   = beat & (s_last | at_top);
  assign take_start = (state == S_IDLE) & start;
  assign to_done    = ((state == S_LOAD) & end_beat & (FLUSH == 0)) |
                      ((state == S_FLUSH) & fs_tick & (fcnt == FW'(FLUSH - 1)));

  assign busy = (state != S_IDLE);
  assign mute = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      fcnt   <= '0;
      err    <= 1'b0;
      c_WE   <= 1'b0;
      c_in   <= '0;
      c_addr <= '0;
    end else begin
      c_WE <= beat;
      if (beat) begin
        c_in   <= s_data;
        c_addr <= cnt;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
            err   <= 1'b0;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (fs_tick) state <= S_LOAD;
        end
        S_LOAD: begin
          // Hold cnt on the ending beat so it never wraps past NC-1.
          if (beat && !end_beat) cnt <= cnt + AW'(1);
          if (end_beat) begin
            err   <= (s_last != at_top);
            fcnt  <= '0;
            state <= (FLUSH == 0) ? S_DONE : S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (fs_tick) begin
            if (fcnt == FW'(FLUSH - 1)) state <= S_DONE;
            else fcnt <= fcnt + FW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIR_COEFF_CHK_EN
  logic [C-1:0] sum;
  logic [C-1:0] sum_upd;
  logic [C-1:0] exp_q;

  // sum_upd folds in the current beat so a FLUSH=0 build still sees the final word.
  assign sum_upd = sum + (beat ? s_data : '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sum     <= '0;
      exp_q   <= '0;
      chk_err <= 1'b0;
    end else if (take_start) begin
      sum     <= '0;
      exp_q   <= exp_sum;
      chk_err <= 1'b0;
    end else begin
      if (beat) sum <= sum_upd;
      if (to_done) chk_err <= (sum_upd != exp_q);
    end
  end
`else
  logic unused_chk;
  assign unused_chk = (^exp_sum) ^ to_done ^ take_start;
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: writes and done-pulse flags are queued at issue time
// and popped by an independent monitor; also exercises FIR_COEFF_CHK_EN when defined.
module tb_fir_coeff_loader;

  localparam int C  = 16;
  localparam int AW = 7;
  localparam int NC = 128;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [C-1:0]  data;
  } wr_t;

  logic          clk;
  logic          nrst;
  logic          start;
  logic          fs_tick;
  logic          s_valid;
  logic [C-1:0]  s_data;
  logic          s_last;
  logic          s_ready;
  logic [C-1:0]  exp_sum;
  logic          c_WE;
  logic [C-1:0]  c_in;
  logic [AW-1:0] c_addr;
  logic          busy;
  logic          mute;
  logic          done;
  logic          err;
  logic          chk_err;

  int   n_cmp = 0;
  int   n_mis = 0;
  wr_t  wr_q[$];
  logic [1:0] done_q[$];

  fir_coeff_loader #(.ORD(256), .C(C), .AW(AW), .FLUSH(2)) dut (
    .clk(clk), .nrst(nrst), .start(start), .fs_tick(fs_tick),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .exp_sum(exp_sum), .c_WE(c_WE), .c_in(c_in), .c_addr(c_addr),
    .busy(busy), .mute(mute), .done(done), .err(err), .chk_err(chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write and every done pulse must match the next queued expectation.
  always @(negedge clk) begin : monitor
    wr_t        e;
    logic [1:0] d;
    if (nrst) begin
      if (c_WE) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL unexpected_write: got addr %0d data %h, required no write", c_addr, c_in);
        end else begin
          e = wr_q.pop_front();
          if (c_addr !== e.addr || c_in !== e.data) begin
            n_mis++;
            $display("[TB] FAIL write: got addr %0d data %h, required addr %0d data %h",
                     c_addr, c_in, e.addr, e.data);
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (done_q.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL unexpected_done: got done with err %b chk_err %b, required no done", err, chk_err);
        end else begin
          d = done_q.pop_front();
          if ({err, chk_err} !== d) begin
            n_mis++;
            $display("[TB] FAIL done_flags: got err %b chk_err %b, required err %b chk_err %b",
                     err, chk_err, d[1], d[0]);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_mis++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    checkOutput({tag, "_c_WE"},    32'(c_WE),    32'd0);
    checkOutput({tag, "_c_in"},    32'(c_in),    32'd0);
    checkOutput({tag, "_c_addr"},  32'(c_addr),  32'd0);
    checkOutput({tag, "_busy"},    32'(busy),    32'd0);
    checkOutput({tag, "_mute"},    32'(mute),    32'd0);
    checkOutput({tag, "_done"},    32'(done),    32'd0);
    checkOutput({tag, "_err"},     32'(err),     32'd0);
    checkOutput({tag, "_chk_err"}, 32'(chk_err), 32'd0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseFs();
    fs_tick = 1'b1;
    @(negedge clk);
    fs_tick = 1'b0;
  endtask

  // Drives one burst; last_idx < 0 means s_last is never raised. Sends at most n_send words.
  task automatic applyStimulus(input int last_idx, input logic [C-1:0] base, input logic [C-1:0] step,
                               input bit gaps, input int n_send, input bit push_done);
    int          e_idx;
    bit          err_e;
    bit          chk_e;
    bit          rdy;
    logic [C-1:0] sum;
    logic [C-1:0] d;
    wr_t         w;
    if (last_idx >= 0 && last_idx < NC - 1) begin
      e_idx = last_idx; err_e = 1'b1;
    end else if (last_idx == NC - 1) begin
      e_idx = NC - 1;   err_e = 1'b0;
    end else begin
      e_idx = NC - 1;   err_e = 1'b1;
    end
    if (n_send > e_idx + 1) n_send = e_idx + 1;
    sum = '0;
    for (int i = 0; i < n_send; i++) begin
      d      = base + C'(i) * step;
      sum    = sum + d;
      w.addr = AW'(i);
      w.data = d;
      wr_q.push_back(w);
    end
`ifdef FIR_COEFF_CHK_EN
    chk_e = (sum != exp_sum);
`else
    chk_e = 1'b0;
`endif
    if (push_done) done_q.push_back({err_e, chk_e});
    for (int i = 0; i < n_send; i++) begin
      if (gaps && i > 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = base + C'(i) * step;
      s_last  = (i == last_idx);
      rdy     = 1'b0;
      for (int k = 0; k < 50; k++) begin
        rdy = s_ready;
        @(negedge clk);
        if (rdy) break;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!rdy) begin
        n_cmp++;
        n_mis++;
        $display("[TB] FAIL beat_timeout: got no s_ready for word %0d, required acceptance within 50 cycles", i);
        return;
      end
      if (i == 0) checkOutput("first_write_latency", 32'(c_WE), 32'd1);
    end
  endtask

  task automatic runFlush();
    pulseFs();
    checkOutput("flush_tick1_done", 32'(done), 32'd0);
    checkOutput("flush_tick1_mute", 32'(mute), 32'd1);
    pulseFs();
    checkOutput("flush_done_pulse", 32'(done), 32'd1);
    checkOutput("flush_done_mute",  32'(mute), 32'd1);
    @(negedge clk);
    checkOutput("after_done_done", 32'(done), 32'd0);
    checkOutput("after_done_mute", 32'(mute), 32'd0);
    checkOutput("after_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    nrst = 1'b0; start = 1'b0; fs_tick = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; exp_sum = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Full load; fs_tick coincident with start must not open the load window.
    $display("[TB] full load");
    start = 1'b1; fs_tick = 1'b1;
    @(negedge clk);
    start = 1'b0; fs_tick = 1'b0;
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_mute", 32'(mute), 32'd1);
    checkOutput("coincident_fs_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    checkOutput("wait_fs_ready", 32'(s_ready), 32'd0);
    pulseFs();
    checkOutput("fs_ready", 32'(s_ready), 32'd1);
    applyStimulus(NC - 1, 16'h0000, 16'h0001, 1'b0, NC, 1'b1);
    checkOutput("full_end_ready", 32'(s_ready), 32'd0);
    checkOutput("full_err", 32'(err), 32'd0);
    runFlush();

    $display("[TB] stream gaps");
    pulseStart();
    pulseFs();
    applyStimulus(15, 16'h1000, 16'h0003, 1'b1, NC, 1'b1);
    checkOutput("gaps_err", 32'(err), 32'd1);
    runFlush();

    $display("[TB] short burst");
    pulseStart();
    checkOutput("start_clears_err", 32'(err), 32'd0);
    pulseFs();
    applyStimulus(10, 16'hA000, 16'h0101, 1'b0, NC, 1'b1);
    checkOutput("short_err", 32'(err), 32'd1);
    checkOutput("short_end_ready", 32'(s_ready), 32'd0);
    runFlush();

    $display("[TB] missing last");
    pulseStart();
    pulseFs();
    applyStimulus(-1, 16'hFFFF, 16'hFFFF, 1'b0, NC, 1'b1);
    checkOutput("missing_err", 32'(err), 32'd1);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("missing_hold_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    pulseStart();
    checkOutput("flush_start_err", 32'(err), 32'd1);
    checkOutput("flush_start_busy", 32'(busy), 32'd1);
    runFlush();
    repeat (3) @(negedge clk);
    checkOutput("start_not_queued", 32'(busy), 32'd0);

    $display("[TB] reset mid-load");
    pulseStart();
    pulseFs();
    applyStimulus(-1, 16'h5500, 16'h0011, 1'b0, 51, 1'b0);
    #1 nrst = 1'b0;
    #1 checkResetValues("midreset");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    pulseStart();
    pulseFs();
    applyStimulus(NC - 1, 16'h7F00, 16'h0007, 1'b0, NC, 1'b1);
    checkOutput("reload_err", 32'(err), 32'd0);
    runFlush();

`ifdef FIR_COEFF_CHK_EN
    $display("[TB] checksum");
    exp_sum = 16'h0000;
    pulseStart();
    pulseFs();
    applyStimulus(NC - 1, 16'h0400, 16'h0000, 1'b0, NC, 1'b1);
    runFlush();
    checkOutput("chk_wrap_ok", 32'(chk_err), 32'd0);
    exp_sum = 16'h0001;
    pulseStart();
    pulseFs();
    applyStimulus(NC - 1, 16'h0400, 16'h0000, 1'b0, NC, 1'b1);
    runFlush();
    checkOutput("chk_mismatch_sticky", 32'(chk_err), 32'd1);
    pulseStart();
    checkOutput("chk_cleared_by_start", 32'(chk_err), 32'd0);
    pulseFs();
    applyStimulus(NC - 1, 16'h0400, 16'h0000, 1'b0, NC, 1'b1);
    runFlush();
`endif

    repeat (2) @(negedge clk);
    checkOutput("writes_pending", 32'(wr_q.size()), 32'd0);
    checkOutput("dones_pending", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient-reload sequencer for the symmetric folded FIR filter. Accepts a burst of coefficient words from a host-side valid/ready stream and writes them into the filter's coefficient port (c_WE/c_in/c_addr), one address per word. Reloads start only on a sample-period boundary. A mute flag covers the reload and a settling window, so the downstream path can hold its output while the delay line flushes.

## Interface

Parameters:
- ORD, 256: filter order; number of stored coefficients NC = (ORD+1)/2 (128 at default)
- C, 16: coefficient width
- AW, $clog2((ORD+1)/2): coefficient address width (7 at default)
- FLUSH, 2: number of fs_tick periods to keep mute asserted after the last write; 0 allowed

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle reload request; ignored unless state is IDLE
- fs_tick  in  1  one-cycle strobe per sample period, from the filter's clock divider
- s_valid  in  1  coefficient word valid
- s_data  in  C  coefficient word, two's complement, index order 0..NC-1
- s_last  in  1  marks the final word of the burst
- s_ready  out  1  loader accepts a word
- exp_sum  in  C  expected checksum, sampled on accepted start (used only with the checksum feature)
- c_WE  out  1  coefficient write enable to the filter
- c_in  out  C  coefficient data to the filter
- c_addr  out  AW  coefficient address to the filter
- busy  out  1  state is not IDLE
- mute  out  1  filter output is invalid (reload or settling in progress)
- done  out  1  one-cycle pulse at the end of a reload
- err  out  1  burst-length error; sticky until the next accepted start
- chk_err  out  1  checksum mismatch; sticky until the next accepted start

## Operation

States and transitions:
- IDLE: start goes to WAIT_FS. Accepting start clears err, chk_err, the word counter and the checksum accumulator.
- WAIT_FS: fs_tick goes to LOAD.
- LOAD: s_ready = 1. Each beat with s_valid & s_ready writes one word at index cnt, then cnt increments.
- LOAD end condition: the burst ends on the first beat where s_last = 1 or cnt = NC-1. That beat is written, then the state goes to FLUSH, or to DONE when FLUSH = 0.
- LOAD err rule: err is set if the ending beat has s_last = 1 with cnt < NC-1 (short burst), or has cnt = NC-1 with s_last = 0 (missing last).
- LOAD short burst: on a short burst, addresses above the last index keep their old contents.
- FLUSH: counts fs_tick. On the FLUSH-th tick the state goes to DONE.
- DONE: done = 1 for one cycle, then the state goes to IDLE.

Output rules:
- mute = 1 in WAIT_FS, LOAD, FLUSH and DONE; 0 in IDLE.
- busy = (state != IDLE).
- s_ready is decoded from the registered state only, with no combinational path from s_valid.
- c_WE, c_in and c_addr are registered. c_in and c_addr hold their last value when c_WE = 0.
- cnt is AW bits wide. It cannot wrap, because the burst is forced to end at NC-1.

Boundary and corner cases:
- start outside IDLE is ignored; it is neither queued nor does it clear flags.
- fs_tick in LOAD is ignored. A write in progress is never interrupted by a sample boundary.
- fs_tick coincident with start is not counted; WAIT_FS waits for the next fs_tick.
- Reset asserted mid-operation returns the block to IDLE immediately. The partially written coefficients stay in the filter; no rollback.

## Timing

- Reset values: s_ready 0, c_WE 0, c_in 0, c_addr 0, busy 0, mute 0, done 0, err 0, chk_err 0; state IDLE; cnt 0.
- start at cycle t: busy and mute are 1 at t+1.
- fs_tick at cycle t in WAIT_FS: s_ready is 1 at t+1.
- Beat accepted at cycle t: c_WE = 1, c_in = s_data and c_addr = its index at t+1. Write latency is 1 cycle.
- Back-to-back beats give back-to-back writes, so the throughput is 1 word per cycle.
- Ending beat at cycle t: s_ready is 0 at t+1, and err (if any) is valid at t+1.
- FLUSH-th fs_tick at cycle t: done = 1 at t+1 and mute = 1 at t+1; mute = 0 and busy = 0 at t+2.
- FLUSH = 0, ending beat at cycle t: done = 1 at t+1.

## Configuration

- Macro FIR_COEFF_CHK_EN.
- Defined: a C-bit accumulator sums every accepted s_data, mod 2^C, unsigned wrap. In DONE, chk_err is set if the sum differs from exp_sum, with chk_err valid in the same cycle as done.
- Not defined: the accumulator is absent, exp_sum is ignored, and chk_err is tied to 0. The port list is identical in both builds.

## Test plan

- Full load, defaults: start, fs_tick, then 128 words 0x0000..0x007F with s_last on word 127 -> c_addr 0..127 written with matching c_in, err 0, done one cycle after the 2nd post-load fs_tick, mute low the next cycle.
- Stream gaps: s_valid toggled every other cycle -> writes only on accepted beats, addresses contiguous, no duplicate or dropped index.
- Short burst: s_last on word 10 -> 11 writes (addr 0..10), err 1 after the ending beat; err cleared on the next accepted start.
- Missing last: 128 words with s_last = 0 -> load ends at addr 127, err 1, s_ready 0 afterward even while s_valid stays high.
- Reset mid-load: nrst low after word 50 -> all outputs at reset values immediately; a subsequent full load completes with err 0.
- Checksum with FIR_COEFF_CHK_EN: 128 words of 0x0400 and exp_sum 0x0000 -> chk_err 0, since the sum wraps to 0x0000. Same burst with exp_sum 0x0001 -> chk_err 1 with done. Start during FLUSH is ignored with flags unchanged.
